// File: rtl/demux_scan_pkg.sv
// Shared constants and FSM state type for the demux scan controller.
// Imported by demux_scan_next and demux_scan_ctrl.
package demux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/demux_scan_next.sv
// Combinational channel search: the lowest enabled channel of a mask and
// the next enabled channel strictly above the current one.
module demux_scan_next
    import demux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found,
    output logic [SEL_W-1:0]  first_ch
);

    // Walking downward means the last hit is the lowest qualifying channel.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        next_ch  = '0;
        found    = 1'b0;
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = SEL_W'(i);
                if (SEL_W'(i) > cur) begin
                    next_ch = SEL_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan controller that steps a 1-to-8 demux select through the enabled channels,
// toggling w every HALF_PERIOD cycles. Define DEMUX_SCAN_LOOP_EN for a continuous scan.
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter int DWELL       = 20,
    parameter int HALF_PERIOD = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              w,
    output logic              busy,
    output logic              done
);

    localparam int DWELL_W = $clog2(DWELL);
    localparam int TOG_W   = $clog2(HALF_PERIOD) + 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(HALF_PERIOD - 1);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                w_q, w_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [TOG_W-1:0]    tog_q, tog_d;

    logic [NUM_CH-1:0]   search_mask;
    logic [SEL_W-1:0]    next_ch;
    logic                next_found;
    logic [SEL_W-1:0]    first_ch;

    // In IDLE the first channel comes from the live mask being accepted;
    // afterwards only the captured copy steers the search.
    assign search_mask = (state_q == IDLE) ? ch_mask : mask_q;

    demux_scan_next u_next (
        .mask     (search_mask),
        .cur      (sel_q),
        .next_ch  (next_ch),
        .found    (next_found),
        .first_ch (first_ch)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        w_d     = w_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dwell_d = dwell_q;
        tog_d   = tog_q;

        unique case (state_q)
            IDLE: begin
                sel_d   = '0;
                w_d     = 1'b0;
                busy_d  = 1'b0;
                dwell_d = '0;
                tog_d   = '0;
                if (start && !stop && (ch_mask != '0)) begin
                    state_d = SCAN;
                    mask_d  = ch_mask;
                    sel_d   = first_ch;
                    busy_d  = 1'b1;
                end
            end

            SCAN: begin
                busy_d = 1'b1;
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    w_d     = 1'b0;
                    busy_d  = 1'b0;
                    dwell_d = '0;
                    tog_d   = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    // Channel change wins over a coincident w toggle.
                    dwell_d = '0;
                    tog_d   = '0;
                    w_d     = 1'b0;
                    if (next_found) begin
                        sel_d = next_ch;
                    end else begin
`ifdef DEMUX_SCAN_LOOP_EN
                        sel_d = first_ch;
`else
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                    if (tog_q == TOG_LAST) begin
                        w_d   = ~w_q;
                        tog_d = '0;
                    end else begin
                        tog_d = tog_q + TOG_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                sel_d   = '0;
                w_d     = 1'b0;
                busy_d  = 1'b0;
                dwell_d = '0;
                tog_d   = '0;
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                w_d     = 1'b0;
                busy_d  = 1'b0;
                dwell_d = '0;
                tog_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dwell_q <= '0;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dwell_q <= dwell_d;
            tog_q   <= tog_d;
        end
    end

    assign sel  = sel_q;
    assign w    = w_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: a scan-position reference model queues the
// expected outputs per edge and an independent monitor compares them one step after.
module tb_demux_scan_ctrl;

    localparam int DWELL       = 20;
    localparam int HALF_PERIOD = 5;

    typedef struct packed {
        logic [2:0] sel;
        logic       w;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] ch_mask;
    logic [2:0] sel;
    logic       w;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    demux_scan_ctrl #(
        .DWELL       (DWELL),
        .HALF_PERIOD (HALF_PERIOD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .ch_mask (ch_mask),
        .sel     (sel),
        .w       (w),
        .busy    (busy),
        .done    (done)
    );

    obs_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cycle     = 0;
    int   exp_done  = 0;
    int   seen_done = 0;

    // Reference model: 0 = idle, 1 = scanning, 2 = done pulse; m_t counts cycles since scan start.
    int   m_mode = 0;
    int   m_t    = 0;
    int   m_chans[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic p, input logic [7:0] m);
        obs_t e;
        int   n;
        if (r) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (s && !p && m != 8'h00) begin
                    m_chans.delete();
                    for (int i = 0; i < 8; i++) if (m[i]) m_chans.push_back(i);
                    m_t    = 0;
                    m_mode = 1;
                end
                1: if (p) begin
                    m_mode = 0;
                end else begin
                    m_t++;
`ifndef DEMUX_SCAN_LOOP_EN
                    if (m_t == m_chans.size() * DWELL) m_mode = 2;
`endif
                end
                default: m_mode = 0;
            endcase
        end
        e = '0;
        n = m_chans.size();
        if (m_mode == 1) begin
            e.sel  = 3'(m_chans[(m_t / DWELL) % n]);
            e.w    = 1'(((m_t % DWELL) / HALF_PERIOD) % 2);
            e.busy = 1'b1;
        end else if (m_mode == 2) begin
            e.sel  = 3'(m_chans[n - 1]);
            e.done = 1'b1;
            exp_done++;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic [7:0] m);
        @(negedge clk);
        rst     = r;
        start   = s;
        stop    = p;
        ch_mask = m;
        @(posedge clk);
        cycle++;
        model_edge(r, s, p, m);
    endtask

    obs_t mon_exp;
    obs_t mon_act;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {sel, w, busy, done};
                if (mon_act.done === 1'b1) seen_done++;
                check("sel_w_busy_done", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        ch_mask = 8'h00;
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);

        // Full scan; random start pulses and mask changes while busy must be ignored.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 170; i++)
            step(1'b0, (i < 150) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 8'($urandom));

        // Sparse mask 0,2,7.
        step(1'b0, 1'b1, 1'b0, 8'b1000_0101);
        repeat (70) step(1'b0, 1'b0, 1'b0, 8'b1000_0101);

        // Empty mask and start together with stop are both ignored.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'hFF);

        // Abort 30 cycles in, on channel 1.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        repeat (30) step(1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'hFF);

        // Stop on the same edge as dwell expiry.
        step(1'b0, 1'b1, 1'b0, 8'h0C);
        repeat (19) step(1'b0, 1'b0, 1'b0, 8'h0C);
        step(1'b0, 1'b0, 1'b1, 8'h0C);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h0C);

        // Reset while on channel 4, overriding start and stop, then a fresh scan.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        repeat (85) step(1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'h30);
        repeat (45) step(1'b0, 1'b0, 1'b0, 8'h30);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 149) == 0), m);
        end
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);

        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_pulse_count", 32'(seen_done), 32'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
